// File: rtl/led_scroll_driver_pkg.sv
// Shared definitions for the scrolling 4-digit LED driver: the character code
// space understood by the downstream 7-segment decoder and the slot FSM states.
package led_scroll_driver_pkg;

    localparam int CHAR_W     = 6;
    localparam int CHAR_MAX   = 36;
    localparam int CHAR_BLANK = 36;
    localparam int NUM_DIGITS = 4;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [1:0]        digit_t;

    // A digit slot starts with all anodes dark, then lights one digit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_t;

    // Active-low anode pattern with only the given digit lit.
    function automatic logic [NUM_DIGITS-1:0] anode_on(input digit_t d);
        return ~(4'b0001 << d);
    endfunction

    // Codes above CHAR_MAX have no glyph in the decoder.
    function automatic logic char_valid(input char_t c);
        return int'(c) <= CHAR_MAX;
    endfunction

endpackage

// File: rtl/led_scroll_driver_if.sv
// Message write port of the LED scroll driver: one word per cycle, with a
// one-cycle error pulse back to the writer when the code is out of range.
interface led_scroll_driver_if #(
    parameter int MSG_LEN = 16
);
    import led_scroll_driver_pkg::*;

    localparam int ADDR_W = $clog2(MSG_LEN);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    char_t             wr_data;
    logic              wr_err;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_err
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_err
    );

endinterface

// File: rtl/led_scroll_driver_msg_buffer.sv
// Message store: MSG_LEN character codes, one synchronous write port and one
// asynchronous read port. A read and a write to the same word in the same
// cycle return the old contents.
module msg_buffer
    import led_scroll_driver_pkg::*;
#(
    parameter int MSG_LEN    = 16,
    parameter int BLANK_CODE = CHAR_BLANK,
    localparam int ADDR_W    = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  char_t             wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output char_t             rd_data
);

    char_t mem [MSG_LEN];

    // Register file: whole message returns to blank glyphs on reset.
    // NOTE: the memory is reset word by word because a freshly reset display
    // must show blanks; this keeps it in flops, which is fine at 16 words.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                mem[i] <= char_t'(BLANK_CODE);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/led_scroll_driver.sv
// Time-multiplexes a 4-character window of a scrolling message onto four
// common-anode 7-segment digits. Each digit slot begins with a dark interval
// so the character code can change while no anode is driven.
module led_scroll_driver
    import led_scroll_driver_pkg::*;
#(
    parameter int DIGIT_TICKS  = 16,
    parameter int BLANK_TICKS  = 4,
    parameter int SCROLL_TICKS = 1 << 22,
    parameter int MSG_LEN      = 16,
    parameter int BLANK_CODE   = CHAR_BLANK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scroll_en,
    led_scroll_driver_if.slave    bus,
    output char_t                 char,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int PTR_W  = $clog2(MSG_LEN);
    localparam int SLOT_W = $clog2(DIGIT_TICKS);
    localparam int SCR_W  = $clog2(SCROLL_TICKS);

    slot_state_t        state;
    logic [SLOT_W-1:0]  slot_cnt;
    digit_t             digit;
    logic [PTR_W-1:0]   ptr;
    logic [SCR_W-1:0]   scr_cnt;
    logic               scroll_pend;

    logic               slot_end;
    logic               blank_end;
    logic               frame_end;
    logic               scr_wrap;
    logic               advance;
    logic               wr_ok;
    digit_t             digit_nxt;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   rd_addr;
    char_t              rd_data;

    // Slot/frame boundary decode and the address of the next digit's char.
    // NOTE: every signal here is assigned on every pass, so no latch can form.
    always_comb begin
        slot_end  = (slot_cnt == SLOT_W'(DIGIT_TICKS - 1));
        blank_end = (state == ST_BLANK) && (slot_cnt == SLOT_W'(BLANK_TICKS - 1));
        frame_end = slot_end && (digit == 2'd0);
        scr_wrap  = scroll_en && (scr_cnt == SCR_W'(SCROLL_TICKS - 1));
        advance   = frame_end && (scroll_pend || scr_wrap);
        digit_nxt = digit - 2'd1;
        ptr_nxt   = advance ? ptr + PTR_W'(1) : ptr;
        // Leftmost digit (3) shows msg[ptr], rightmost (0) shows msg[ptr+3].
        rd_addr   = ptr_nxt + PTR_W'(2'd3 - digit_nxt);
        wr_ok     = bus.wr_en && char_valid(bus.wr_data);
    end

    msg_buffer #(
        .MSG_LEN    (MSG_LEN),
        .BLANK_CODE (BLANK_CODE)
    ) u_msg_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Slot FSM, digit/ptr/scroll counters and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BLANK;
            slot_cnt    <= '0;
            digit       <= 2'd3;
            ptr         <= '0;
            scr_cnt     <= '0;
            scroll_pend <= 1'b0;
            char        <= char_t'(BLANK_CODE);
            an          <= '1;
            bus.wr_err  <= 1'b0;
        end else begin
            bus.wr_err <= bus.wr_en && !char_valid(bus.wr_data);

            if (scroll_en) begin
                scr_cnt <= scr_wrap ? '0 : scr_cnt + SCR_W'(1);
            end

            // A pending step is applied only between frames so all four
            // digits of one refresh share the same window position.
            if (advance) begin
                ptr         <= ptr_nxt;
                scroll_pend <= 1'b0;
            end else if (scr_wrap) begin
                scroll_pend <= 1'b1;
            end

            if (slot_end) begin
                state    <= ST_BLANK;
                slot_cnt <= '0;
                digit    <= digit_nxt;
                an       <= '1;
                char     <= rd_data;
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
                if (blank_end) begin
                    state <= ST_ON;
                    an    <= anode_on(digit);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scroll_driver.sv
// Randomized self-checking bench for led_scroll_driver. A time-based model
// derives the display from the cycle count since reset, the message contents
// and the number of enabled scroll cycles.
module tb_led_scroll_driver;
    import led_scroll_driver_pkg::*;

    localparam int DT = 8;
    localparam int BT = 2;
    localparam int ST = 64;
    localparam int ML = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scroll_en = 1'b0;
    char_t       char_o;
    logic [3:0]  an_o;

    int vectors = 0;
    int miscompares = 0;

    led_scroll_driver_if #(.MSG_LEN(ML)) bus ();

    led_scroll_driver #(
        .DIGIT_TICKS  (DT),
        .BLANK_TICKS  (BT),
        .SCROLL_TICKS (ST),
        .MSG_LEN      (ML),
        .BLANK_CODE   (CHAR_BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scroll_en (scroll_en),
        .bus       (bus),
        .char      (char_o),
        .an        (an_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    char_t      m_msg [ML];
    int         m_ptr, m_t, m_en, m_used;
    char_t      m_char;
    logic [3:0] m_an;
    logic       m_err;

    // One clock edge: update the model from the inputs seen at that edge,
    // then step 1 time unit past the edge so DUT outputs are settled.
    task automatic cycle();
        int s, slot;
        @(posedge clk);
        if (reset) begin
            foreach (m_msg[i]) m_msg[i] = char_t'(CHAR_BLANK);
            m_ptr = 0; m_t = 0; m_en = 0; m_used = 0;
            m_char = char_t'(CHAR_BLANK); m_an = 4'hF; m_err = 1'b0;
        end else begin
            m_t++;
            if (scroll_en) m_en++;
            s    = m_t % DT;
            slot = (m_t / DT) % 4;
            if ((m_t % (4 * DT)) == 0 && (m_en / ST) > m_used) begin
                m_ptr  = (m_ptr + 1) % ML;
                m_used = m_en / ST;
            end
            if (s == 0) m_char = m_msg[(m_ptr + slot) % ML];
            m_an  = (s < BT) ? 4'hF : ~(4'b0001 << (3 - slot));
            m_err = bus.wr_en && (int'(bus.wr_data) > CHAR_MAX);
            if (bus.wr_en && int'(bus.wr_data) <= CHAR_MAX)
                m_msg[bus.wr_addr] = bus.wr_data;
        end
        #1;
    endtask

    // Continuous invariants: at most one anode low; char moves only when dark.
    char_t prev_char;
    logic  mon_on = 1'b0;
    always @(negedge clk) begin
        if (mon_on) begin
            vectors++;
            if ($countones(~an_o) > 1) begin
                miscompares++;
                $display("FAIL one_anode t=%0d an=%b, want at most one low", m_t, an_o);
            end
            vectors++;
            if (char_o !== prev_char && an_o !== 4'hF) begin
                miscompares++;
                $display("FAIL char_stable t=%0d char %0d->%0d with an=%b, want an=1111", m_t, prev_char, char_o, an_o);
            end
            prev_char = char_o;
        end
    end

    task automatic test_reset();
        reset = 1'b1; scroll_en = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) cycle();
        vectors++;
        if ({an_o, char_o, bus.wr_err} !== {4'hF, char_t'(CHAR_BLANK), 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got an=%b char=%0d err=%b, want an=1111 char=36 err=0", an_o, char_o, bus.wr_err);
        end
        prev_char = char_o;
        mon_on = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 4 * 4 * DT; i++) begin
            cycle();
            vectors++;
            if ({an_o, char_o, bus.wr_err} !== {m_an, m_char, m_err}) begin
                miscompares++;
                $display("FAIL blank_scan t=%0d got an=%b char=%0d err=%b, want an=%b char=%0d err=%b", m_t, an_o, char_o, bus.wr_err, m_an, m_char, m_err);
            end
        end
    endtask

    task automatic test_static_msg();
        int d;
        scroll_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = char_t'(i + 1);
            cycle();
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 8 * DT; i++) begin
            cycle();
            vectors++;
            if ({an_o, char_o, bus.wr_err} !== {m_an, m_char, m_err}) begin
                miscompares++;
                $display("FAIL static t=%0d got an=%b char=%0d err=%b, want an=%b char=%0d err=%b", m_t, an_o, char_o, bus.wr_err, m_an, m_char, m_err);
            end
        end
        // With ptr at 0, digit d lit means msg[3-d] = 4-d on the display.
        for (int i = 0; i < 4 * DT; i++) begin
            cycle();
            if (an_o !== 4'hF) begin
                case (an_o)
                    4'b0111: d = 3;
                    4'b1011: d = 2;
                    4'b1101: d = 1;
                    4'b1110: d = 0;
                    default: d = -1;
                endcase
                vectors++;
                if (d < 0 || char_o !== char_t'(4 - d)) begin
                    miscompares++;
                    $display("FAIL static_digit t=%0d an=%b char=%0d, want char=%0d", m_t, an_o, char_o, 4 - d);
                end
            end
        end
    endtask

    task automatic test_scroll();
        scroll_en = 1'b0;
        for (int i = 0; i < ML; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = char_t'(i);
            cycle();
        end
        bus.wr_en = 1'b0;
        scroll_en = 1'b1;
        for (int i = 0; i < 18 * ST; i++) begin
            cycle();
            vectors++;
            if ({an_o, char_o, bus.wr_err} !== {m_an, m_char, m_err}) begin
                miscompares++;
                $display("FAIL scroll t=%0d ptr=%0d got an=%b char=%0d, want an=%b char=%0d", m_t, m_ptr, an_o, char_o, m_an, m_char);
            end
        end
        scroll_en = 1'b0;
    endtask

    task automatic test_wr_err();
        int addr;
        addr = (m_ptr + int'($urandom_range(0, 3))) % ML;
        bus.wr_en = 1'b1; bus.wr_addr = 4'(addr); bus.wr_data = char_t'(37);
        cycle();
        bus.wr_en = 1'b0;
        vectors++;
        if (bus.wr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_err_set got %b, want 1", bus.wr_err);
        end
        cycle();
        vectors++;
        if (bus.wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_err_pulse got %b, want 0", bus.wr_err);
        end
        bus.wr_en = 1'b1; bus.wr_data = char_t'(63);
        cycle();
        bus.wr_en = 1'b1; bus.wr_data = char_t'(36);
        cycle();
        bus.wr_en = 1'b0;
        vectors++;
        if (bus.wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_err_36 got %b, want 0", bus.wr_err);
        end
        for (int i = 0; i < 8 * DT; i++) begin
            cycle();
            vectors++;
            if ({an_o, char_o, bus.wr_err} !== {m_an, m_char, m_err}) begin
                miscompares++;
                $display("FAIL wr_check t=%0d got an=%b char=%0d err=%b, want an=%b char=%0d err=%b", m_t, an_o, char_o, bus.wr_err, m_an, m_char, m_err);
            end
        end
    endtask

    task automatic test_read_before_write();
        int addr, slot_n;
        char_t old_v;
        scroll_en = 1'b0;
        for (int trial = 0; trial < 8; trial++) begin
            for (int k = 0; k < DT && (m_t % DT) != DT - 1; k++) cycle();
            vectors++;
            if ((m_t % DT) != DT - 1) begin
                miscompares++;
                $display("FAIL rbw_align timeout t=%0d", m_t);
            end
            slot_n = ((m_t + 1) / DT) % 4;
            addr   = (m_ptr + slot_n) % ML;
            old_v  = m_msg[addr];
            bus.wr_en = 1'b1; bus.wr_addr = 4'(addr);
            bus.wr_data = char_t'((int'(old_v) + 1 + int'($urandom_range(0, 30))) % 37);
            cycle();
            bus.wr_en = 1'b0;
            vectors++;
            if (char_o !== old_v) begin
                miscompares++;
                $display("FAIL rbw_old t=%0d got char=%0d, want old %0d", m_t, char_o, old_v);
            end
            for (int i = 0; i < 5 * DT; i++) begin
                cycle();
                vectors++;
                if ({an_o, char_o, bus.wr_err} !== {m_an, m_char, m_err}) begin
                    miscompares++;
                    $display("FAIL rbw t=%0d got an=%b char=%0d, want an=%b char=%0d", m_t, an_o, char_o, m_an, m_char);
                end
            end
        end
    endtask

    task automatic test_random();
        scroll_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 4'($urandom_range(0, ML - 1));
            bus.wr_data = char_t'($urandom_range(0, 40));
            if ($urandom_range(0, 199) == 0) scroll_en = ~scroll_en;
            cycle();
            vectors++;
            if ({an_o, char_o, bus.wr_err} !== {m_an, m_char, m_err}) begin
                miscompares++;
                $display("FAIL random t=%0d got an=%b char=%0d err=%b, want an=%b char=%0d err=%b", m_t, an_o, char_o, bus.wr_err, m_an, m_char, m_err);
            end
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        scroll_en = 1'b1;
        for (int i = 0; i < 2000 && m_ptr != 5; i++) cycle();
        scroll_en = 1'b0;
        vectors++;
        if (m_ptr != 5) begin
            miscompares++;
            $display("FAIL reset_mid_ptr timeout ptr=%0d, want 5", m_ptr);
        end
        // Wait for the ON phase of digit 1 (third slot of the frame).
        for (int i = 0; i < 8 * DT && !((m_t % (4 * DT)) >= 2 * DT + BT && (m_t % (4 * DT)) < 3 * DT); i++) cycle();
        vectors++;
        if (an_o !== 4'b1101) begin
            miscompares++;
            $display("FAIL reset_mid_phase got an=%b, want 1101", an_o);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        vectors++;
        if ({an_o, char_o, bus.wr_err} !== {4'hF, char_t'(CHAR_BLANK), 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid got an=%b char=%0d err=%b, want an=1111 char=36 err=0", an_o, char_o, bus.wr_err);
        end
        // Scroll the whole message through the window: every word must be blank.
        scroll_en = 1'b1;
        for (int i = 0; i < 17 * ST; i++) begin
            cycle();
            vectors++;
            if ({an_o, char_o, bus.wr_err} !== {m_an, char_t'(CHAR_BLANK), 1'b0}) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got an=%b char=%0d err=%b, want an=%b char=36 err=0", m_t, an_o, char_o, bus.wr_err, m_an);
            end
        end
        scroll_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static_msg();
        test_scroll();
        test_wr_err();
        test_read_before_write();
        test_random();
        test_reset_mid();
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
